// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the shift-and-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mult_state_e;

    // Counter must hold 0..N-1; sized as ceil(log2(N+1)) to match the divider.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/mult_clk_gate.sv
// Glitch-free clock gate: enable is captured while the clock is low.
module mult_clk_gate (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic gclk
);

    logic en_q;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q <= 1'b0;
        end else begin
            en_q <= en;
        end
    end

    assign gclk = clk & en_q;

endmodule

// File: rtl/mult_datapath.sv
// Multiplicand, accumulator and multiplier/product-low registers with the
// conditional adder and one-bit right shifter.
import mult_pkg::*;

module mult_datapath #(
    parameter int C_NUM_BITS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic                      step,
    input  logic [C_NUM_BITS-1:0]     a,
    input  logic [C_NUM_BITS-1:0]     b,
    output logic [2*C_NUM_BITS-1:0]   prod_next
);

    localparam int N = C_NUM_BITS;

    logic [N-1:0] mcand_q, mcand_d;
    logic [N:0]   acc_q, acc_d;
    logic [N-1:0] mq_q, mq_d;
    logic [N:0]   addend;
    logic [N:0]   sum;
    logic [2*N:0] shifted;

    always_comb begin
        addend  = mq_q[0] ? {1'b0, mcand_q} : '0;
        sum     = acc_q + addend;
        shifted = {sum, mq_q} >> 1;
    end

    // Product as it will stand after this step; the top latches it on the last one.
    assign prod_next = shifted[2*N-1:0];

    always_comb begin
        mcand_d = mcand_q;
        acc_d   = acc_q;
        mq_d    = mq_q;
        if (load) begin
            mcand_d = a;
            acc_d   = '0;
            mq_d    = b;
        end else if (step) begin
            acc_d = shifted[2*N:N];
            mq_d  = shifted[N-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q <= '0;
            acc_q   <= '0;
            mq_q    <= '0;
        end else begin
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
        end
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier, one multiplier bit per GCK edge.
// Optional macro MULT_ZERO_SKIP_EN: zero operands finish in a single cycle.
import mult_pkg::*;

module shift_add_multiplier #(
    parameter int C_NUM_BITS = 4
) (
    input  logic                      CK,
    input  logic                      RN,
    input  logic                      E,
    input  logic                      START,
    input  logic [C_NUM_BITS-1:0]     A,
    input  logic [C_NUM_BITS-1:0]     B,
    output logic [2*C_NUM_BITS-1:0]   P,
    output logic                      VALID,
    output logic                      BUSY
);

    localparam int N     = C_NUM_BITS;
    localparam int CNT_W = cnt_width(C_NUM_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    logic gck;

    mult_clk_gate u_clk_gate (
        .clk   (CK),
        .rst_n (RN),
        .en    (E),
        .gclk  (gck)
    );

    mult_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2*N-1:0]   p_q, p_d;
    logic             valid_q, valid_d;
    logic             load;
    logic             step;
    logic [2*N-1:0]   prod_next;

    mult_datapath #(
        .C_NUM_BITS (C_NUM_BITS)
    ) u_datapath (
        .clk       (gck),
        .rst_n     (RN),
        .load      (load),
        .step      (step),
        .a         (A),
        .b         (B),
        .prod_next (prod_next)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        valid_d = 1'b0;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (START) begin
                    load  = 1'b1;
                    cnt_d = '0;
`ifdef MULT_ZERO_SKIP_EN
                    if ((A == '0) || (B == '0)) begin
                        state_d = ST_DONE;
                        p_d     = '0;
                        valid_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
`else
                    state_d = ST_RUN;
`endif
                end
            end
            ST_RUN: begin
                step  = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    p_d     = prod_next;
                    valid_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge gck or negedge RN) begin
        if (!RN) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            valid_q <= valid_d;
        end
    end

    assign P     = p_q;
    assign VALID = valid_q;
    assign BUSY  = (state_q == ST_RUN);

endmodule
